// File: rtl/onehot_to_bin_enc.sv
// onehot_to_bin_enc: registered one-hot to binary encoder behind a 2-entry
// valid/ready output buffer, with per-beat illegal-code flag and a
// saturating error counter.
//
// Ports:
//   clk        - clock, all state on rising edge
//   reset      - asynchronous active-low reset
//   valid_i    - input beat valid
//   onehot_i   - one-hot code, sampled on push
//   ready_o    - encoder can accept a beat (buffer not full)
//   valid_o    - buffer head occupied
//   bin_o      - encoded index of buffer head
//   err_o      - buffer head was not exactly one-hot
//   ready_i    - downstream accepts head this cycle
//   clr_cnt_i  - synchronous clear of err_cnt_o (wins over increment)
//   err_cnt_o  - saturating count of accepted illegal beats
module onehot_to_bin_enc #(
    parameter int unsigned ONEHOT_W = 16,
    parameter int unsigned BIN_W    = $clog2(ONEHOT_W),
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [ONEHOT_W-1:0] onehot_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [BIN_W-1:0]    bin_o,
    output logic                err_o,
    input  logic                ready_i,
    input  logic                clr_cnt_i,
    output logic [CNT_W-1:0]    err_cnt_o
);

    localparam int unsigned CNT_SLOTS_W = 2;

    // Buffer entry 0 is always the head, so outputs come straight from flops.
    logic [CNT_SLOTS_W-1:0] count_q,    count_d;
    logic [BIN_W-1:0]       head_bin_q, head_bin_d;
    logic                   head_err_q, head_err_d;
    logic [BIN_W-1:0]       tail_bin_q, tail_bin_d;
    logic                   tail_err_q, tail_err_d;
    logic                   valid_q,    valid_d;
    logic                   ready_q,    ready_d;
    logic [CNT_W-1:0]       err_cnt_q,  err_cnt_d;

    logic [BIN_W-1:0]       enc_bin_c;
    logic                   enc_err_c;
    logic                   push_c;
    logic                   pop_c;

    assign push_c = valid_i && ready_q;
    assign pop_c  = valid_q && ready_i;

    // Lowest set bit wins; zero or multi-hot flags an error.
    always_comb begin
        enc_bin_c = '0;
        for (int i = int'(ONEHOT_W) - 1; i >= 0; i--) begin
            if (onehot_i[i]) begin
                enc_bin_c = BIN_W'(i);
            end
        end
        enc_err_c = (onehot_i == '0) ||
                    ((onehot_i & (onehot_i - ONEHOT_W'(1))) != '0);
    end

    // Buffer, flag and counter next-state.
    always_comb begin
        count_d    = count_q;
        head_bin_d = head_bin_q;
        head_err_d = head_err_q;
        tail_bin_d = tail_bin_q;
        tail_err_d = tail_err_q;
        err_cnt_d  = err_cnt_q;

        if (push_c && !pop_c) begin
            if (count_q == CNT_SLOTS_W'(0)) begin
                head_bin_d = enc_bin_c;
                head_err_d = enc_err_c;
            end else begin
                tail_bin_d = enc_bin_c;
                tail_err_d = enc_err_c;
            end
            count_d = count_q + CNT_SLOTS_W'(1);
        end else if (!push_c && pop_c) begin
            // Empty buffer keeps the last popped head on the outputs.
            if (count_q == CNT_SLOTS_W'(2)) begin
                head_bin_d = tail_bin_q;
                head_err_d = tail_err_q;
            end
            count_d = count_q - CNT_SLOTS_W'(1);
        end else if (push_c && pop_c) begin
            if (count_q == CNT_SLOTS_W'(1)) begin
                head_bin_d = enc_bin_c;
                head_err_d = enc_err_c;
            end else begin
                head_bin_d = tail_bin_q;
                head_err_d = tail_err_q;
                tail_bin_d = enc_bin_c;
                tail_err_d = enc_err_c;
            end
        end

        valid_d = (count_d != CNT_SLOTS_W'(0));
        ready_d = (count_d != CNT_SLOTS_W'(2));

        if (clr_cnt_i) begin
            err_cnt_d = '0;
        end else if (push_c && enc_err_c && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            head_bin_q <= '0;
            head_err_q <= 1'b0;
            tail_bin_q <= '0;
            tail_err_q <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            err_cnt_q  <= '0;
        end else begin
            count_q    <= count_d;
            head_bin_q <= head_bin_d;
            head_err_q <= head_err_d;
            tail_bin_q <= tail_bin_d;
            tail_err_q <= tail_err_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign ready_o   = ready_q;
    assign valid_o   = valid_q;
    assign bin_o     = head_bin_q;
    assign err_o     = head_err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_onehot_to_bin_enc.sv
// tb_onehot_to_bin_enc: scoreboard bench for onehot_to_bin_enc. Stimulus
// pushes hand-computed {bin, err} into a queue on each accepted beat; a
// monitor pops and compares whenever the DUT pops its head.
module tb_onehot_to_bin_enc;

    localparam int unsigned ONEHOT_W = 16;
    localparam int unsigned BIN_W    = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned BOUND    = 100;

    logic                clk;
    logic                reset;
    logic                valid_i;
    logic [ONEHOT_W-1:0] onehot_i;
    logic                ready_o;
    logic                valid_o;
    logic [BIN_W-1:0]    bin_o;
    logic                err_o;
    logic                ready_i;
    logic                clr_cnt_i;
    logic [CNT_W-1:0]    err_cnt_o;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    onehot_to_bin_enc #(
        .ONEHOT_W (ONEHOT_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .onehot_i  (onehot_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .bin_o     (bin_o),
        .err_o     (err_o),
        .ready_i   (ready_i),
        .clr_cnt_i (clr_cnt_i),
        .err_cnt_o (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: a beat visible at negedge with ready_i high pops at next edge.
    always @(negedge clk) begin
        if (reset && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bin_o", int'(bin_o), int'(e.bin));
                chk("err_o", int'(err_o), int'(e.err));
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [ONEHOT_W-1:0] code,
                        input logic [BIN_W-1:0] exp_bin, input logic exp_err);
        int waited;
        exp_t e;
        valid_i  = 1'b1;
        onehot_i = code;
        waited   = 0;
        @(negedge clk);
        while (!ready_o && waited < int'(BOUND)) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        if (!ready_o) begin
            chk("send_timeout", 0, 1);
        end else begin
            e.bin = exp_bin;
            e.err = exp_err;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset     = 1'b0;
        valid_i   = 1'b0;
        onehot_i  = '0;
        ready_i   = 1'b1;
        clr_cnt_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_ready_o", int'(ready_o), 1);
        chk("rst_bin_o", int'(bin_o), 0);
        chk("rst_err_o", int'(err_o), 0);
        chk("rst_err_cnt", int'(err_cnt_o), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        idle(1);

        // Legal codes back-to-back
        send(16'h0001, 4'd0, 1'b0);
        send(16'h0100, 4'd8, 1'b0);
        send(16'h8000, 4'd15, 1'b0);
        idle(3);
        chk("legal_err_cnt", int'(err_cnt_o), 0);

        // Illegal codes: zero and multi-hot
        send(16'h0000, 4'd0, 1'b1);
        send(16'h0A00, 4'd9, 1'b1);
        idle(3);
        chk("illegal_err_cnt", int'(err_cnt_o), 2);

        // Full buffer backpressure
        ready_i = 1'b0;
        send(16'h0004, 4'd2, 1'b0);
        @(negedge clk);
        chk("one_entry_latency_valid", int'(valid_o), 1);
        chk("one_entry_ready", int'(ready_o), 1);
        @(posedge clk); #1;
        send(16'h0010, 4'd4, 1'b0);
        valid_i  = 1'b1;
        onehot_i = 16'h0020;
        @(negedge clk);
        chk("full_ready_o", int'(ready_o), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_ready_hold", int'(ready_o), 0);
        chk("full_valid_o", int'(valid_o), 1);
        chk("full_head_bin", int'(bin_o), 2);
        @(posedge clk); #1;
        ready_i = 1'b1;
        @(negedge clk);
        chk("ready_before_pop", int'(ready_o), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_pop", int'(ready_o), 1);
        begin
            exp_t e;
            e.bin = 4'd5;
            e.err = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        idle(3);

        // Simultaneous push and pop with one entry buffered
        ready_i = 1'b0;
        send(16'h0002, 4'd1, 1'b0);
        ready_i  = 1'b1;
        valid_i  = 1'b1;
        onehot_i = 16'h0080;
        @(negedge clk);
        chk("pp_ready_o", int'(ready_o), 1);
        begin
            exp_t e;
            e.bin = 4'd7;
            e.err = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk);
        chk("pp_valid_o", int'(valid_o), 1);
        chk("pp_count1_ready", int'(ready_o), 1);
        chk("pp_head_bin", int'(bin_o), 7);
        @(posedge clk); #1;
        ready_i = 1'b1;
        idle(3);
        chk("pp_drained", int'(valid_o), 0);

        // Error counter saturation and clear
        for (int i = 0; i < 300; i++) send(16'h0003, 4'd0, 1'b1);
        idle(2);
        chk("err_cnt_sat", int'(err_cnt_o), 255);
        valid_i   = 1'b1;
        onehot_i  = 16'h0003;
        clr_cnt_i = 1'b1;
        @(negedge clk);
        if (ready_o) begin
            exp_t e;
            e.bin = 4'd0;
            e.err = 1'b1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_i   = 1'b0;
        clr_cnt_i = 1'b0;
        @(negedge clk);
        chk("err_cnt_clear", int'(err_cnt_o), 0);
        @(posedge clk); #1;
        send(16'h0006, 4'd1, 1'b1);
        idle(2);
        chk("err_cnt_after_clear", int'(err_cnt_o), 1);

        // Reset with two beats buffered
        ready_i = 1'b0;
        send(16'h0004, 4'd2, 1'b0);
        send(16'h0010, 4'd4, 1'b0);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid_o", int'(valid_o), 0);
        chk("midrst_ready_o", int'(ready_o), 1);
        chk("midrst_err_cnt", int'(err_cnt_o), 0);
        chk("midrst_bin_o", int'(bin_o), 0);
        @(negedge clk);
        reset   = 1'b1;
        ready_i = 1'b1;
        @(posedge clk); #1;
        send(16'h0040, 4'd6, 1'b0);
        idle(3);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
